// File: rtl/mem_resp_queue.sv
// mem_resp_queue: in-order tracker for outstanding data-memory requests that aligns load data for WB.
// Optional macro MEM_RESP_BYPASS_EN forwards a head response to WB in the cycle it arrives.
module mem_resp_queue #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_load,
  input  logic [1:0]                req_size,
  input  logic                      req_sext,
  input  logic [$clog2(DW/8)-1:0]   req_off,
  input  logic [TAGW-1:0]           req_tag,
  input  logic                      data_ok,
  input  logic [DW-1:0]             rdata,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic [TAGW-1:0]           out_tag,
  output logic                      out_is_load,
  output logic                      busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(DW/8);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW:0]   FULL_X = (CW+1)'(DEPTH);

  function automatic logic [DW-1:0] align_load(input logic [DW-1:0] d, input logic [1:0] sz,
                                               input logic sx, input logic [OW-1:0] off);
    logic [DW-1:0] sh;
    logic [DW-1:0] r;
    logic          sgn;
    int            nb;
    sh = d >> {off, 3'b000};
    // size 3 collapses to the full bus width, which is a word on a 32-bit bus
    case (sz)
      2'd0:    begin nb = 8;  sgn = sh[7];    end
      2'd1:    begin nb = 16; sgn = sh[15];   end
      2'd2:    begin nb = 32; sgn = sh[31];   end
      default: begin nb = DW; sgn = sh[DW-1]; end
    endcase
    for (int i = 0; i < DW; i++) r[i] = (i < nb) ? sh[i] : (sx & sgn);
    return r;
  endfunction

  function automatic logic [CW-1:0] sat_discard(input logic [CW:0] v);
    return (v > FULL_X) ? FULL : v[CW-1:0];
  endfunction

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rsp_ptr_q, rsp_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, pend_q, pend_d, discard_cnt_q, discard_cnt_d;
  logic            is_load_q [DEPTH];
  logic            is_load_d [DEPTH];
  logic [1:0]      size_q    [DEPTH];
  logic [1:0]      size_d    [DEPTH];
  logic            sext_q    [DEPTH];
  logic            sext_d    [DEPTH];
  logic [OW-1:0]   off_q     [DEPTH];
  logic [OW-1:0]   off_d     [DEPTH];
  logic [TAGW-1:0] tag_q     [DEPTH];
  logic [TAGW-1:0] tag_d     [DEPTH];
  logic [DW-1:0]   data_q    [DEPTH];
  logic [DW-1:0]   data_d    [DEPTH];
  logic            done_q    [DEPTH];
  logic            done_d    [DEPTH];

  logic          rsp_take, rsp_drop, byp, pop, issue;
  logic [DW-1:0] cap_data;

  // Response classification and WB-facing outputs
  always_comb begin
    rsp_drop = data_ok & (discard_cnt_q != '0);
    rsp_take = data_ok & (discard_cnt_q == '0) & (pend_q != '0);
    cap_data = is_load_q[rsp_ptr_q]
             ? align_load(rdata, size_q[rsp_ptr_q], sext_q[rsp_ptr_q], off_q[rsp_ptr_q]) : '0;
`ifdef MEM_RESP_BYPASS_EN
    byp = rsp_take & (count_q != '0) & (rsp_ptr_q == rd_ptr_q) & ~done_q[rd_ptr_q] & ~flush;
`else
    byp = 1'b0;
`endif
    out_valid   = ~flush & (count_q != '0) & (done_q[rd_ptr_q] | byp);
    out_data    = byp ? cap_data : (out_valid ? data_q[rd_ptr_q] : '0);
    out_tag     = tag_q[rd_ptr_q];
    out_is_load = is_load_q[rd_ptr_q];
    req_ready   = (count_q != FULL);
    busy        = (count_q != '0) | (discard_cnt_q != '0);
    pop         = out_valid & out_ready;
    issue       = req_valid & req_ready & ~flush;
  end

  // Next-state: flush overrides issue, capture and pop
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rsp_ptr_d     = rsp_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pend_d        = pend_q;
    discard_cnt_d = discard_cnt_q - {{PW{1'b0}}, rsp_drop};
    is_load_d     = is_load_q;
    size_d        = size_q;
    sext_d        = sext_q;
    off_d         = off_q;
    tag_d         = tag_q;
    data_d        = data_q;
    done_d        = done_q;
    if (flush) begin
      wr_ptr_d      = '0;
      rsp_ptr_d     = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      pend_d        = '0;
      discard_cnt_d = sat_discard({1'b0, discard_cnt_q} + {1'b0, pend_q}
                                  - {{CW{1'b0}}, rsp_drop | rsp_take});
      for (int i = 0; i < DEPTH; i++) done_d[i] = 1'b0;
    end else begin
      if (issue) begin
        is_load_d[wr_ptr_q] = req_is_load;
        size_d[wr_ptr_q]    = req_size;
        sext_d[wr_ptr_q]    = req_sext;
        off_d[wr_ptr_q]     = req_off;
        tag_d[wr_ptr_q]     = req_tag;
        done_d[wr_ptr_q]    = 1'b0;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (rsp_take) begin
        data_d[rsp_ptr_q] = cap_data;
        done_d[rsp_ptr_q] = 1'b1;
        rsp_ptr_d         = rsp_ptr_q + 1'b1;
      end
      // a bypassed retire clears the done bit set just above, so it never lingers
      if (pop) begin
        done_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = rd_ptr_q + 1'b1;
      end
      case ({issue, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      case ({issue, rsp_take})
        2'b10:   pend_d = pend_q + 1'b1;
        2'b01:   pend_d = pend_q - 1'b1;
        default: pend_d = pend_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rsp_ptr_q     <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pend_q        <= '0;
      discard_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        is_load_q[i] <= 1'b0;
        size_q[i]    <= '0;
        sext_q[i]    <= 1'b0;
        off_q[i]     <= '0;
        tag_q[i]     <= '0;
        data_q[i]    <= '0;
        done_q[i]    <= 1'b0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rsp_ptr_q     <= rsp_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      discard_cnt_q <= discard_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        is_load_q[i] <= is_load_d[i];
        size_q[i]    <= size_d[i];
        sext_q[i]    <= sext_d[i];
        off_q[i]     <= off_d[i];
        tag_q[i]     <= tag_d[i];
        data_q[i]    <= data_d[i];
        done_q[i]    <= done_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed bench for mem_resp_queue: a 32-bit/DEPTH=4 instance plus a 64-bit instance for wide alignment.
module tb_mem_resp_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_is_load, req_sext, data_ok, flush, out_ready;
  logic [1:0]  req_size, req_off;
  logic [4:0]  req_tag;
  logic [31:0] rdata;
  logic        req_ready, out_valid, out_is_load, busy;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        b_req_valid, b_req_is_load, b_req_sext, b_data_ok, b_flush, b_out_ready;
  logic [1:0]  b_req_size;
  logic [2:0]  b_req_off;
  logic [4:0]  b_req_tag;
  logic [63:0] b_rdata;
  logic        b_req_ready, b_out_valid, b_out_is_load, b_busy;
  logic [63:0] b_out_data;
  logic [4:0]  b_out_tag;

  int checks = 0;
  int errors = 0;

  mem_resp_queue #(.DW(32), .DEPTH(4), .TAGW(5)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_size(req_size), .req_sext(req_sext), .req_off(req_off),
    .req_tag(req_tag), .data_ok(data_ok), .rdata(rdata), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_is_load(out_is_load),
    .busy(busy));

  mem_resp_queue #(.DW(64), .DEPTH(4), .TAGW(5)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_is_load(b_req_is_load), .req_size(b_req_size), .req_sext(b_req_sext), .req_off(b_req_off),
    .req_tag(b_req_tag), .data_ok(b_data_ok), .rdata(b_rdata), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag), .out_is_load(b_out_is_load),
    .busy(b_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic ld, input logic [1:0] sz, input logic sx, input logic [1:0] off,
                         input logic [4:0] tag);
    req_valid = 1'b1; req_is_load = ld; req_size = sz; req_sext = sx; req_off = off; req_tag = tag;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic resp_a(input logic [31:0] d);
    data_ok = 1'b1; rdata = d;
    tick();
    data_ok = 1'b0;
  endtask

  task automatic pop_a();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic issue_b(input logic [1:0] sz, input logic sx, input logic [2:0] off);
    b_req_valid = 1'b1; b_req_is_load = 1'b1; b_req_size = sz; b_req_sext = sx; b_req_off = off;
    b_req_tag = 5'd2;
    tick();
    b_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (b_busy !== 1'b0 || b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_b busy=%b ready=%b want 0/1", b_busy, b_req_ready); end
  endtask

  task automatic test_sext_load();
    issue_a(1'b1, 2'd0, 1'b1, 2'd3, 5'd7);
    resp_a(32'h80FF_1234);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sext_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL sext_data got %h want ffffff80", out_data); end
    checks++; if (out_tag !== 5'd7) begin errors++; $display("FAIL sext_tag got %0d want 7", out_tag); end
    checks++; if (out_is_load !== 1'b1) begin errors++; $display("FAIL sext_is_load got %b want 1", out_is_load); end
    pop_a();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sext_drain valid=%b busy=%b want 0/0", out_valid, busy); end
    issue_a(1'b1, 2'd1, 1'b1, 2'd2, 5'd6);
    resp_a(32'h8001_0000);
    checks++; if (out_data !== 32'hFFFF_8001) begin errors++; $display("FAIL half_sext_data got %h want ffff8001", out_data); end
    pop_a();
  endtask

  task automatic test_full_in_order();
    for (int i = 0; i < 4; i++) issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'(i + 1));
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", req_ready); end
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd31);
    for (int i = 0; i < 4; i++) resp_a(32'(17 * (i + 1)));
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_during_pop got %b want 0", req_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL order_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_data !== 32'(17 * (i + 1))) begin errors++; $display("FAIL order_data[%0d] got %h want %h", i, out_data, 32'(17 * (i + 1))); end
      checks++; if (out_tag !== 5'(i + 1)) begin errors++; $display("FAIL order_tag[%0d] got %0d want %0d", i, out_tag, i + 1); end
      tick();
      if (i == 0) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %b want 1", req_ready); end
      end
    end
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_drain valid=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'(i + 1));
    resp_a(32'h5);
    flush = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got %b want 0", out_valid); end
    tick();
    flush = 1'b0;
    checks++; if (dut_a.discard_cnt_q !== 3'd2) begin errors++; $display("FAIL flush_discard got %0d want 2", dut_a.discard_cnt_q); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_after valid=%b busy=%b want 0/1", out_valid, busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", req_ready); end
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd9);
    resp_a(32'hA);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_a_valid got %b want 0", out_valid); end
    resp_a(32'hB);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_b_valid got %b want 0", out_valid); end
    resp_a(32'hC);
    checks++; if (out_valid !== 1'b1 || out_tag !== 5'd9) begin errors++; $display("FAIL post_flush valid=%b tag=%0d want 1/9", out_valid, out_tag); end
    checks++; if (out_data !== 32'hC) begin errors++; $display("FAIL post_flush_data got %h want c", out_data); end
    pop_a();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_flush_busy got %b want 0", busy); end
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd1);
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd2);
    flush = 1'b1; data_ok = 1'b1; rdata = 32'h0;
    tick();
    flush = 1'b0; data_ok = 1'b0;
    checks++; if (dut_a.discard_cnt_q !== 3'd1) begin errors++; $display("FAIL flush_rsp_discard got %0d want 1", dut_a.discard_cnt_q); end
    resp_a(32'h1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_rsp_busy got %b want 0", busy); end
  endtask

  task automatic test_store_and_stray();
    issue_a(1'b0, 2'd2, 1'b0, 2'd0, 5'd4);
    resp_a(32'hDEAD_BEEF);
    checks++; if (out_valid !== 1'b1 || out_is_load !== 1'b0) begin errors++; $display("FAIL store valid=%b is_load=%b want 1/0", out_valid, out_is_load); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL store_data got %h want 0", out_data); end
    pop_a();
    resp_a(32'h99);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stray_rsp busy=%b valid=%b want 0/0", busy, out_valid); end
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd3);
    resp_a(32'h77);
    checks++; if (out_data !== 32'h77) begin errors++; $display("FAIL after_stray_data got %h want 77", out_data); end
    pop_a();
  endtask

  task automatic test_latency();
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd3);
    data_ok = 1'b1; rdata = 32'h55; out_ready = 1'b1;
    #1;
`ifdef MEM_RESP_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin errors++; $display("FAIL bypass valid=%b data=%h want 1/55", out_valid, out_data); end
    tick();
    data_ok = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_retire busy=%b valid=%b want 0/0", busy, out_valid); end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass_valid got %b want 0", out_valid); end
    tick();
    data_ok = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin errors++; $display("FAIL latency valid=%b data=%h want 1/55", out_valid, out_data); end
    tick();
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL latency_retire busy=%b want 0", busy); end
`endif
  endtask

  task automatic test_dw64();
    issue_b(2'd1, 1'b0, 3'd6);
    b_data_ok = 1'b1; b_rdata = 64'hBEEF_0000_0000_0000;
    tick();
    b_data_ok = 1'b0;
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 64'h0000_0000_0000_BEEF) begin errors++; $display("FAIL dw64_half valid=%b data=%h want 1/beef", b_out_valid, b_out_data); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    issue_b(2'd2, 1'b1, 3'd4);
    b_data_ok = 1'b1; b_rdata = 64'h8000_0001_0000_0000;
    tick();
    b_data_ok = 1'b0;
    checks++; if (b_out_data !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL dw64_word_sext got %h want ffffffff80000001", b_out_data); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    issue_b(2'd3, 1'b1, 3'd0);
    b_data_ok = 1'b1; b_rdata = 64'h8123_4567_89AB_CDEF;
    tick();
    b_data_ok = 1'b0;
    checks++; if (b_out_data !== 64'h8123_4567_89AB_CDEF) begin errors++; $display("FAIL dw64_dword got %h want 8123456789abcdef", b_out_data); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL dw64_busy got %b want 0", b_busy); end
  endtask

  task automatic test_reset_mid();
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd1);
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd2);
    flush = 1'b1; tick(); flush = 1'b0;
    issue_a(1'b1, 2'd2, 1'b0, 2'd0, 5'd3);
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (busy !== 1'b0 || dut_a.discard_cnt_q !== 3'd0) begin errors++; $display("FAIL reset_mid busy=%b discard=%0d want 0/0", busy, dut_a.discard_cnt_q); end
    checks++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid ready=%b valid=%b want 1/0", req_ready, out_valid); end
  endtask

  initial begin
    req_valid = 0; req_is_load = 0; req_size = 0; req_sext = 0; req_off = 0; req_tag = 0;
    data_ok = 0; rdata = 0; flush = 0; out_ready = 0;
    b_req_valid = 0; b_req_is_load = 0; b_req_size = 0; b_req_sext = 0; b_req_off = 0; b_req_tag = 0;
    b_data_ok = 0; b_rdata = 0; b_flush = 0; b_out_ready = 0;
    test_reset();
    test_sext_load();
    test_full_in_order();
    test_flush();
    test_store_and_stray();
    test_latency();
    test_dw64();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
